ysyx_23060136_exu_div: RTL and testbench

Iterative radix-2 integer divider for the EXU, the inverse of the pipelined multiplier. It sits beside the multiplier and uses the same valid/ready request and held-result handshake. It executes RV64M DIV/DIVU/REM/REMU and the W variants, producing quotient and remainder together. Latency is data-independent except for the divide-by-zero and signed-overflow early exits.

---
 rtl/ysyx_23060136_div_pkg.sv | 25 ++
 rtl/ysyx_23060136_div_step.sv | 21 ++
 rtl/ysyx_23060136_exu_div.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060136_exu_div.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060136_div_pkg.sv
// Shared types and constants for the EXU radix-2 divider.
package ysyx_23060136_div_pkg;

  localparam int BITS_W = 64;
  localparam int ITER_D = 64;
  localparam int ITER_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Most-negative / -1 on the active operand width; caller gates with signedness.
  function automatic logic is_signed_ovf(input logic [BITS_W-1:0] a,
                                         input logic [BITS_W-1:0] b,
                                         input logic w);
    logic ovf_w;
    logic ovf_d;
    ovf_w = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ovf_d = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    return w ? ovf_w : ovf_d;
  endfunction

endpackage

// File: rtl/ysyx_23060136_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module ysyx_23060136_div_step
  import ysyx_23060136_div_pkg::*;
(
  input  logic [BITS_W-1:0] prem,
  input  logic              in_bit,
  input  logic [BITS_W-1:0] dsr,
  output logic [BITS_W-1:0] next_rem,
  output logic              q_bit
);

  logic [BITS_W:0]   shifted;
  logic [BITS_W-1:0] sub;

  // prem < dsr always holds, so a successful difference fits back in BITS_W bits
  assign shifted  = {prem, in_bit};
  assign q_bit    = (shifted >= {1'b0, dsr});
  assign sub      = shifted[BITS_W-1:0] - dsr;
  assign next_rem = q_bit ? sub : shifted[BITS_W-1:0];

endmodule

// File: rtl/ysyx_23060136_exu_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
module ysyx_23060136_exu_div
  import ysyx_23060136_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              div_valid,
  input  logic              divw,
  input  logic              div_signed,
  input  logic [BITS_W-1:0] dividend,
  input  logic [BITS_W-1:0] divisor,
  output logic              div_ready,
  output logic              div_out_valid,
  output logic [BITS_W-1:0] quotient,
  output logic [BITS_W-1:0] remainder
);

  div_state_e        state;
  div_state_e        next_state;
  logic [5:0]        cnt;
  logic [BITS_W-1:0] prem;
  logic [BITS_W-1:0] dvd;
  logic [BITS_W-1:0] dsr;
  logic              w_op;
  logic              q_neg;
  logic              r_neg;
  logic              special;

  logic              accept;
  logic              last_iter;
  logic [BITS_W-1:0] a_ext, b_ext, a_mag, b_mag;
  logic              sa, sb, div_zero, ovf;
  logic [BITS_W-1:0] step_rem;
  logic              step_q;
  logic [BITS_W-1:0] q_sel, r_sel, q_fix, r_fix;

  assign div_ready = (state == IDLE);
  assign accept    = div_valid & div_ready & ~flush;
  assign last_iter = w_op ? (cnt == 6'(ITER_W - 1)) : (cnt == 6'(ITER_D - 1));

  // Operand extension, sign/magnitude split and early-exit detection
  always_comb begin
    a_ext = divw ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
    b_ext = divw ? {{32{div_signed & divisor[31]}}, divisor[31:0]} : divisor;
    sa    = div_signed & a_ext[BITS_W-1];
    sb    = div_signed & b_ext[BITS_W-1];
    a_mag = sa ? (~a_ext + 64'd1) : a_ext;
    b_mag = sb ? (~b_ext + 64'd1) : b_ext;
    div_zero = (b_ext == 64'd0);
    ovf      = div_signed & is_signed_ovf(dividend, divisor, divw);
  end

  ysyx_23060136_div_step u_step (
    .prem     (prem),
    .in_bit   (dvd[BITS_W-1]),
    .dsr      (dsr),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // Sign fix-up (skipped for early exits) and W-result sign extension
  always_comb begin
    q_sel = (q_neg & ~special) ? (~dvd + 64'd1) : dvd;
    r_sel = (r_neg & ~special) ? (~prem + 64'd1) : prem;
    q_fix = w_op ? {{32{q_sel[31]}}, q_sel[31:0]} : q_sel;
    r_fix = w_op ? {{32{r_sel[31]}}, r_sel[31:0]} : r_sel;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = IDLE;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = accept ? ((div_zero | ovf) ? FIX : CALC) : IDLE;
        CALC:    next_state = last_iter ? FIX : CALC;
        FIX:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Datapath: operand latch, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 6'd0;
      prem          <= 64'd0;
      dvd           <= 64'd0;
      dsr           <= 64'd0;
      w_op          <= 1'b0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      special       <= 1'b0;
      div_out_valid <= 1'b0;
      quotient      <= 64'd0;
      remainder     <= 64'd0;
    end else if (flush) begin
      div_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_out_valid <= 1'b0;
            cnt           <= 6'd0;
            w_op          <= divw;
            q_neg         <= sa ^ sb;
            r_neg         <= sa;
            dsr           <= b_mag;
            special       <= div_zero | ovf;
            // Early exits park the final q/r in the iteration registers
            if (div_zero) begin
              dvd  <= 64'hFFFF_FFFF_FFFF_FFFF;
              prem <= a_ext;
            end else if (ovf) begin
              dvd  <= a_ext;
              prem <= 64'd0;
            end else begin
              dvd  <= divw ? {a_mag[31:0], 32'd0} : a_mag;
              prem <= 64'd0;
            end
          end
        end
        CALC: begin
          prem <= step_rem;
          dvd  <= {dvd[BITS_W-2:0], step_q};
          cnt  <= cnt + 6'd1;
        end
        FIX: begin
          quotient      <= q_fix;
          remainder     <= r_fix;
          div_out_valid <= 1'b1;
        end
        default: begin
          div_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_exu_div.sv
// Self-checking bench: directed cases plus random operations against an arithmetic reference.
module tb_ysyx_23060136_exu_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        divw = 1'b0;
  logic        div_signed = 1'b0;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        div_ready;
  logic        div_out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int checks = 0;
  int fails  = 0;
  logic [63:0] prev_q = 64'd0;
  logic [63:0] prev_r = 64'd0;

  ysyx_23060136_exu_div dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .div_valid     (div_valid),
    .divw          (divw),
    .div_signed    (div_signed),
    .dividend      (dividend),
    .divisor       (divisor),
    .div_ready     (div_ready),
    .div_out_valid (div_out_valid),
    .quotient      (quotient),
    .remainder     (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics written directly with SV arithmetic
  task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
    logic signed [63:0] a64, b64, q64, r64;
    logic signed [31:0] a32, b32, q32, r32;
    logic [31:0] uq32, ur32;
    lat = w ? 33 : 65;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'sd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF;
        r = {{32{a32[31]}}, a32};
        lat = 1;
      end else if (s && a32 == 32'sh8000_0000 && b32 == -32'sd1) begin
        q = {{32{a32[31]}}, a32};
        r = 64'd0;
        lat = 1;
      end else if (s) begin
        q32 = a32 / b32;
        r32 = a32 % b32;
        q = {{32{q32[31]}}, q32};
        r = {{32{r32[31]}}, r32};
      end else begin
        uq32 = a[31:0] / b[31:0];
        ur32 = a[31:0] % b[31:0];
        q = {{32{uq32[31]}}, uq32};
        r = {{32{ur32[31]}}, ur32};
      end
    end else begin
      a64 = a;
      b64 = b;
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF;
        r = a;
        lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a;
        r = 64'd0;
        lat = 1;
      end else if (s) begin
        q64 = a64 / b64;
        r64 = a64 % b64;
        q = q64;
        r = r64;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  // Issue one request, scramble operands after accept, and check latency/results
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s,
                       input string tag);
    logic [63:0] eq, er;
    int lat_exp;
    int lat;
    bit ready_bad;
    ref_div(a, b, w, s, eq, er, lat_exp);
    @(negedge clk);
    check({tag, ".ready_in"}, {63'd0, div_ready}, 64'd1);
    div_valid = 1'b1; divw = w; div_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    div_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor = {$urandom, $urandom};
    divw = 1'($urandom_range(0, 1));
    div_signed = 1'($urandom_range(0, 1));
    check({tag, ".valid_clr"}, {63'd0, div_out_valid}, 64'd0);
    check({tag, ".q_hold"}, quotient, prev_q);
    lat = 0;
    ready_bad = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (div_out_valid) break;
      if (div_ready) ready_bad = 1'b1;
    end
    check({tag, ".latency"}, 64'(lat), 64'(lat_exp));
    check({tag, ".ready_busy"}, {63'd0, ready_bad}, 64'd0);
    check({tag, ".ready_done"}, {63'd0, div_ready}, 64'd1);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    logic [63:0] a, b;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {63'd0, div_ready}, 64'd1);
    check("rst.valid", {63'd0, div_out_valid}, 64'd0);
    check("rst.q", quotient, 64'd0);
    check("rst.r", remainder, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(64'd100, 64'd7, 1'b0, 1'b0, "divu_100_7");
    do_op(-64'sd7, 64'd2, 1'b0, 1'b1, "div_m7_2");
    do_op(64'd7, -64'sd2, 1'b0, 1'b1, "div_7_m2");
    do_op(64'h1234, 64'd0, 1'b0, 1'b0, "divu_zero");
    do_op(64'h0000_0000_8000_0000, 64'd0, 1'b1, 1'b1, "divw_zero");
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "div_ovf");
    do_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, "divw_ovf");
    do_op(64'h0000_0000_FFFF_FFFF, 64'd2, 1'b1, 1'b0, "divuw");
    do_op(64'hAAAA_AAAA_FFFF_FFF9, 64'd2, 1'b1, 1'b1, "remw");

    // Flush at cycle 10 of a 64-bit op
    @(negedge clk);
    div_valid = 1'b1; divw = 1'b0; div_signed = 1'b0;
    dividend = 64'd1000; divisor = 64'd3;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.valid", {63'd0, div_out_valid}, 64'd0);
    check("flush.ready", {63'd0, div_ready}, 64'd1);
    check("flush.q", quotient, prev_q);
    check("flush.r", remainder, prev_r);

    // Request coincident with flush is dropped
    @(negedge clk);
    div_valid = 1'b1; flush = 1'b1; dividend = 64'd50; divisor = 64'd5;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    check("flushreq.ready", {63'd0, div_ready}, 64'd1);
    check("flushreq.valid", {63'd0, div_out_valid}, 64'd0);

    do_op(64'd9, 64'd3, 1'b0, 1'b1, "div_9_3");

    // Reset mid-CALC
    @(negedge clk);
    div_valid = 1'b1; divw = 1'b0; div_signed = 1'b1;
    dividend = 64'd12345; divisor = 64'd17;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check("rstmid.ready", {63'd0, div_ready}, 64'd1);
    check("rstmid.valid", {63'd0, div_out_valid}, 64'd0);
    check("rstmid.q", quotient, 64'd0);
    check("rstmid.r", remainder, 64'd0);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    prev_q = 64'd0;
    prev_r = 64'd0;

    // Randomised operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 9));
        2: b = 64'hFFFF_FFFF_FFFF_FFFF;
        3: begin a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        4: b = b >> $urandom_range(0, 62);
        5: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
        default: a = a >> $urandom_range(0, 40);
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
